spi_frame_reader: RTL and testbench

// - SPI master, mode 0, that reads 16-bit frames from the board's SPI slave output path (SPI_cs/SPI_clk/SPI_MISO).
// - Each frame carries one 12-bit ADC sample, MSB first; the 12 data bits are the low 12 of the 16.
// - Sits on the host/bridge side of the link and hands each sample to downstream logic as data_out with a one-cycle data_valid strobe.

---
 rtl/spi_reader_pkg.sv | 27 ++
 rtl/spi_sclk_gen.sv | 44 ++++
 rtl/spi_frame_reader.sv | 174 +++++++++++++++++
 tb/tb_spi_frame_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reader_pkg.sv
// Shared types and helpers for the SPI frame reader.
//   state_t        : reader FSM states
//   FRAME_BITS_DEF : default SPI_clk rising edges per frame
//   DATA_BITS_DEF  : default payload width (frame LSBs)
//   clog2()        : counter width needed to hold values 0..v-1 (minimum 1)
package spi_reader_pkg;

    localparam int unsigned FRAME_BITS_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: SPI_clk toggles every CLK_DIV clk cycles while en is high,
// and idles low (divider cleared) while en is low.
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   en           in   run the divider
//   spi_clk      out  registered SPI clock
//   rise_tick_c  out  combinational: next edge takes spi_clk 0->1
//   fall_tick_c  out  combinational: next edge takes spi_clk 1->0
module spi_sclk_gen
    import spi_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic spi_clk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned DIV_W = clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap_c;

    assign wrap_c      = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick_c = wrap_c && !spi_clk;
    assign fall_tick_c = wrap_c && spi_clk;

    // Half-period counter and clock toggle
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
        end else if (wrap_c) begin
            div_cnt <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_reader.sv
// Mode-0 SPI master reading one FRAME_BITS frame per request; the low
// DATA_BITS are the payload, any set bit above them flags frame_err.
// Optional feature macro: SPI_READER_AUTO_TRIG_EN (interrupt rising edge
// acts as start, with one pending request held while busy).
//   clk_50M     in   system clock
//   reset       in   synchronous, active-high
//   start       in   one-cycle read request, ignored while busy
//   interrupt   in   slave new-data flag (auto-trigger build only)
//   SPI_MISO    in   serial data from the slave
//   SPI_clk     out  SPI clock, idles low
//   SPI_cs      out  chip select, active low
//   busy        out  accepted start through the data_valid cycle
//   data_out    out  last received payload
//   data_valid  out  one-cycle strobe with data_out/frame_err
//   frame_err   out  upper frame bits non-zero
module spi_frame_reader
    import spi_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 interrupt,
    input  logic                 SPI_MISO,
    output logic                 SPI_clk,
    output logic                 SPI_cs,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err
);

    localparam int unsigned CNT_W = clog2((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int unsigned BIT_W = clog2(FRAME_BITS + 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
    logic                    cs_nxt, busy_nxt, data_valid_nxt, frame_err_nxt;
    logic [DATA_BITS-1:0]    data_out_nxt;
    logic                    trig_c, shift_en_c, rise_c, fall_c;

    assign shift_en_c = (state == SHIFT);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .clk        (clk_50M),
        .reset      (reset),
        .en         (shift_en_c),
        .spi_clk    (SPI_clk),
        .rise_tick_c(rise_c),
        .fall_tick_c(fall_c)
    );

`ifdef SPI_READER_AUTO_TRIG_EN
    logic irq_s1, irq_s2, irq_s3, pending;
    logic irq_edge_c;

    assign irq_edge_c = irq_s2 && !irq_s3;
    // Start, an interrupt edge and a held request merge into one trigger
    assign trig_c     = start || irq_edge_c || pending;

    // Interrupt synchronizer, edge history and single pending request
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            irq_s1  <= 1'b0;
            irq_s2  <= 1'b0;
            irq_s3  <= 1'b0;
            pending <= 1'b0;
        end else begin
            irq_s1 <= interrupt;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (irq_edge_c) begin
                pending <= 1'b1;
            end
        end
    end
`else
    logic unused_interrupt;
    assign unused_interrupt = interrupt;
    assign trig_c           = start;
`endif

    // State and registered outputs
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            SPI_cs     <= 1'b1;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            SPI_cs     <= cs_nxt;
            busy       <= busy_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        data_out_nxt   = data_out;
        frame_err_nxt  = frame_err;
        data_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (trig_c) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(CS_SETUP - 1)) begin
                    state_nxt   = SHIFT;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (rise_c) begin
                    shreg_nxt   = {shreg[FRAME_BITS-2:0], SPI_MISO};
                    bit_cnt_nxt = bit_cnt + BIT_W'(1);
                end
                // Leave only once SPI_clk has returned low after the last rise
                if (fall_c && (bit_cnt == BIT_W'(FRAME_BITS))) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(CS_HOLD - 1)) begin
                    state_nxt      = IDLE;
                    data_out_nxt   = shreg[DATA_BITS-1:0];
                    frame_err_nxt  = |shreg[FRAME_BITS-1:DATA_BITS];
                    data_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        cs_nxt   = (state_nxt == IDLE);
        // busy spans the strobe cycle even though the FSM is already idle
        busy_nxt = (state_nxt != IDLE) || data_valid_nxt;
    end

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader: a default instance (CLK_DIV=4) and a
// CLK_DIV=2 instance, each with a mode-0 slave model driving MISO on SPI_clk fall.
module tb_spi_frame_reader;

    logic        clk;
    logic        reset;
    logic        start1, start2, irq1, irq2, miso1, miso2;
    logic        sclk1, cs1, busy1, dv1, ferr1;
    logic        sclk2, cs2, busy2, dv2, ferr2;
    logic [11:0] dout1, dout2;
    logic [15:0] frame1, frame2;
    logic [4:0]  fall_cnt1, fall_cnt2;

    int n_chk = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_frame_reader u_dut (
        .clk_50M(clk), .reset(reset), .start(start1), .interrupt(irq1),
        .SPI_MISO(miso1), .SPI_clk(sclk1), .SPI_cs(cs1), .busy(busy1),
        .data_out(dout1), .data_valid(dv1), .frame_err(ferr1)
    );

    spi_frame_reader #(.CLK_DIV(2)) u_dut2 (
        .clk_50M(clk), .reset(reset), .start(start2), .interrupt(irq2),
        .SPI_MISO(miso2), .SPI_clk(sclk2), .SPI_cs(cs2), .busy(busy2),
        .data_out(dout2), .data_valid(dv2), .frame_err(ferr2)
    );

    // Slave models: MSB out at CS fall, next bit after every SPI_clk fall
    always @(negedge sclk1 or posedge cs1) begin
        if (cs1) fall_cnt1 <= 5'd0;
        else     fall_cnt1 <= fall_cnt1 + 5'd1;
    end
    always @(negedge sclk2 or posedge cs2) begin
        if (cs2) fall_cnt2 <= 5'd0;
        else     fall_cnt2 <= fall_cnt2 + 5'd1;
    end
    assign miso1 = frame1[4'(5'd15 - fall_cnt1)];
    assign miso2 = frame2[4'(5'd15 - fall_cnt2)];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    // Starts a frame at edge N and samples every cycle up to N+len.
    // Extra start pulses are sampled at edges N+e1 and N+e2 (-1 = none).
    task automatic frame_run(input bit sel, input logic [15:0] frm, input int len,
                             input int e1, input int e2,
                             output int dv_off, output int dv_cnt, output int cs_low,
                             output int rises, output int busy_off, output logic last_cs,
                             output logic [11:0] dout, output logic ferr);
        logic        prev, s_cs, s_clk, s_busy, s_dv, s_ferr;
        logic [11:0] s_dout;
        if (sel) frame2 = frm;
        else     frame1 = frm;
        dv_off = -1; dv_cnt = 0; cs_low = 0; rises = 0; busy_off = -1;
        prev = 1'b0; dout = '0; ferr = 1'b0; last_cs = 1'b0;
        drive(sel, 1'b1);
        step();
        for (int k = 0; k <= len; k++) begin
            s_cs   = sel ? cs2   : cs1;
            s_clk  = sel ? sclk2 : sclk1;
            s_busy = sel ? busy2 : busy1;
            s_dv   = sel ? dv2   : dv1;
            s_ferr = sel ? ferr2 : ferr1;
            s_dout = sel ? dout2 : dout1;
            if (!s_cs) cs_low++;
            if (s_dv) begin
                if (dv_off < 0) dv_off = k;
                dv_cnt++;
                dout = s_dout;
                ferr = s_ferr;
            end
            if (s_clk && !prev) rises++;
            prev = s_clk;
            if (!s_busy && busy_off < 0) busy_off = k;
            last_cs = s_cs;
            if (k == len) break;
            drive(sel, (k + 1 == e1) || (k + 1 == e2));
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          dv_off, dv_cnt, cs_low, rises, busy_off, seen;
        logic        last_cs, ferr;
        logic [11:0] dout;

        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; irq1 = 1'b0; irq2 = 1'b0;
        frame1 = 16'h0000; frame2 = 16'h0000;
        repeat (3) step();
        check("rst_cs",    32'(cs1),   32'd1);
        check("rst_sclk",  32'(sclk1), 32'd0);
        check("rst_busy",  32'(busy1), 32'd0);
        check("rst_dv",    32'(dv1),   32'd0);
        check("rst_dout",  32'(dout1), 32'd0);
        check("rst_ferr",  32'(ferr1), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Frame with upper-nibble error, stray starts at N+10 and N+132
        frame_run(1'b0, 16'hF123, 132, 10, 132,
                  dv_off, dv_cnt, cs_low, rises, busy_off, last_cs, dout, ferr);
        check("a_dv_off",  32'(dv_off), 32'd132);
        check("a_dv_cnt",  32'(dv_cnt), 32'd1);
        check("a_cs_low",  32'(cs_low), 32'd132);
        check("a_cs_up",   32'(last_cs), 32'd1);
        check("a_rises",   32'(rises),  32'd16);
        check("a_dout",    32'(dout),   32'h123);
        check("a_ferr",    32'(ferr),   32'd1);

        // Back-to-back frame accepted at N+133
        frame_run(1'b0, 16'h0ABC, 140, -1, -1,
                  dv_off, dv_cnt, cs_low, rises, busy_off, last_cs, dout, ferr);
        check("b_dv_off",  32'(dv_off),   32'd132);
        check("b_dv_cnt",  32'(dv_cnt),   32'd1);
        check("b_cs_low",  32'(cs_low),   32'd132);
        check("b_rises",   32'(rises),    32'd16);
        check("b_busy_off", 32'(busy_off), 32'd133);
        check("b_dout",    32'(dout),     32'hABC);
        check("b_ferr",    32'(ferr),     32'd0);
        check("b_hold",    32'(dout1),    32'hABC);

        // Reset sampled at N+60, mid SHIFT
        frame1 = 16'h0555;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (59) step();
        check("r_busy_pre", 32'(busy1), 32'd1);
        reset = 1'b1;
        step();
        check("r_cs",   32'(cs1),   32'd1);
        check("r_sclk", 32'(sclk1), 32'd0);
        check("r_busy", 32'(busy1), 32'd0);
        check("r_dout", 32'(dout1), 32'd0);
        check("r_dv",   32'(dv1),   32'd0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (dv1 || !cs1) seen++;
        end
        check("r_quiet", 32'(seen), 32'd0);

        // CLK_DIV=2 instance
        frame_run(1'b1, 16'h0FFF, 80, -1, -1,
                  dv_off, dv_cnt, cs_low, rises, busy_off, last_cs, dout, ferr);
        check("d2_dv_off",  32'(dv_off),   32'd68);
        check("d2_dv_cnt",  32'(dv_cnt),   32'd1);
        check("d2_cs_low",  32'(cs_low),   32'd68);
        check("d2_rises",   32'(rises),    32'd16);
        check("d2_busy_off", 32'(busy_off), 32'd69);
        check("d2_dout",    32'(dout),     32'hFFF);
        check("d2_ferr",    32'(ferr),     32'd0);

`ifdef SPI_READER_AUTO_TRIG_EN
        // Interrupt rises after edge M; frame must start at edge M+3
        frame1 = 16'h0055;
        step();
        irq1 = 1'b1;
        step();
        step();
        check("irq_m2", 32'(cs1), 32'd1);
        step();
        check("irq_m3", 32'(cs1), 32'd0);
        repeat (7) step();
        irq1 = 1'b0;
        repeat (10) step();
        irq1 = 1'b1;
        repeat (115) step();
        check("irq_dv",   32'(dv1),   32'd1);
        check("irq_dout", 32'(dout1), 32'h055);
        check("irq_cs_up", 32'(cs1),  32'd1);
        step();
        check("irq_pend", 32'(cs1), 32'd0);
        repeat (140) step();
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (!cs1) seen++;
        end
        check("irq_single", 32'(seen), 32'd0);
        irq1 = 1'b0;
`else
        // Interrupt must have no effect in the default build
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) irq1 = ~irq1;
            step();
            if (!cs1 || busy1) seen++;
        end
        irq1 = 1'b0;
        check("irq_unused", 32'(seen), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
